// File: rtl/code_lock.sv
// code_lock: two-key serial code lock with entry timeout and a timed unlock window.
// Define LOCKOUT_EN to add a lockout state after three consecutive failed entries.
module code_lock #(
  parameter int unsigned          CODE_LEN       = 4,
  parameter logic [CODE_LEN-1:0]  CODE           = 4'b1011,
  parameter int unsigned          TIMEOUT        = 2_000_000,
  parameter int unsigned          OPEN_CYCLES    = 50_000_000,
  parameter int unsigned          LOCKOUT_CYCLES = 100_000_000
) (
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic       X0_deb,
  input  logic       X1_deb,
  output logic       unlock,
  output logic       error,
  output logic       busy,
  output logic [4:0] bit_count
);

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // One shared counter times ENTRY gaps, the OPEN window and the lockout window.
  localparam int unsigned CNT_MAX = max_u(max_u(TIMEOUT, OPEN_CYCLES), LOCKOUT_CYCLES);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] OPEN_LAST    = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [4:0]       LAST_COUNT   = 5'(CODE_LEN - 1);

`ifdef LOCKOUT_EN
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_OPEN,
    S_FAIL,
    S_LOCKOUT
  } state_t;

  logic [1:0] fail_cnt;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_OPEN,
    S_FAIL
  } state_t;
`endif

  state_t              state;
  logic [CODE_LEN-1:0] shreg;
  logic [CNT_W-1:0]    timer;

  logic                valid_key;
  logic                key_bit;
  logic                last_key;
  logic                timed_out;
  logic                match;
  logic                open_now;
  logic                fail_now;
  logic [CODE_LEN-1:0] shifted;

  // Both keys in the same cycle is ambiguous and is treated as no key.
  assign valid_key = X0_deb ^ X1_deb;
  assign key_bit   = X1_deb;

  // In IDLE the partial code starts from zeros; in ENTRY older bits move toward the MSB.
  assign shifted  = (state == S_IDLE) ? CODE_LEN'(key_bit) : CODE_LEN'({shreg, key_bit});
  assign match    = (shifted == CODE);
  assign last_key = (state == S_IDLE) ? (CODE_LEN == 1) : (bit_count == LAST_COUNT);

  assign timed_out = (state == S_ENTRY) && !valid_key && (timer == TIMEOUT_LAST);
  assign open_now  = (state == S_IDLE || state == S_ENTRY) && valid_key && last_key && match;
  assign fail_now  = ((state == S_IDLE || state == S_ENTRY) && valid_key && last_key && !match)
                     || timed_out;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      shreg     <= '0;
      timer     <= '0;
      bit_count <= '0;
      unlock    <= 1'b0;
      error     <= 1'b0;
      busy      <= 1'b0;
`ifdef LOCKOUT_EN
      fail_cnt  <= '0;
`endif
    end else begin
      // NOTE: error defaults low every cycle, so it can only ever be a one-cycle pulse.
      error <= 1'b0;

      case (state)
        S_IDLE, S_ENTRY: begin
          if (open_now) begin
            state     <= S_OPEN;
            unlock    <= 1'b1;
            busy      <= 1'b1;
            shreg     <= '0;
            timer     <= '0;
            bit_count <= '0;
`ifdef LOCKOUT_EN
            fail_cnt  <= '0;
`endif
          end else if (fail_now) begin
            state     <= S_FAIL;
            error     <= 1'b1;
            busy      <= 1'b1;
            shreg     <= '0;
            timer     <= '0;
            bit_count <= '0;
`ifdef LOCKOUT_EN
            fail_cnt  <= fail_cnt + 2'd1;
`endif
          end else if (valid_key) begin
            state     <= S_ENTRY;
            busy      <= 1'b1;
            shreg     <= shifted;
            timer     <= '0;
            bit_count <= bit_count + 5'd1;
          end else if (state == S_ENTRY) begin
            timer <= timer + CNT_W'(1);
          end
        end

        S_OPEN: begin
          if (timer == OPEN_LAST) begin
            state  <= S_IDLE;
            unlock <= 1'b0;
            busy   <= 1'b0;
            timer  <= '0;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end

        S_FAIL: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          timer <= '0;
`ifdef LOCKOUT_EN
          // Third consecutive failure: hold off all keys for the lockout window.
          if (fail_cnt == 2'd3) begin
            state <= S_LOCKOUT;
            busy  <= 1'b1;
          end
`endif
        end

`ifdef LOCKOUT_EN
        S_LOCKOUT: begin
          if (timer == LOCK_LAST) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            timer    <= '0;
            fail_cnt <= '0;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
`endif

        default: begin
          state     <= S_IDLE;
          unlock    <= 1'b0;
          busy      <= 1'b0;
          shreg     <= '0;
          timer     <= '0;
          bit_count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_lock.sv
// Self-checking bench for code_lock: absolute-cycle reference model plus an event scoreboard.
// Unlock/error events are predicted when keys are driven and matched by an independent monitor.
module tb_code_lock;

  localparam int          CODE_LEN       = 4;
  localparam logic [3:0]  CODE           = 4'b1011;
  localparam int          TIMEOUT        = 100;
  localparam int          OPEN_CYCLES    = 50;
  localparam int          LOCKOUT_CYCLES = 200;

  localparam int EV_UNLOCK = 1;
  localparam int EV_ERROR  = 2;

  logic       sysclk  = 1'b0;
  logic       reset_n = 1'b0;
  logic       X0_deb  = 1'b0;
  logic       X1_deb  = 1'b0;
  logic       unlock;
  logic       error;
  logic       busy;
  logic [4:0] bit_count;

  code_lock #(
    .CODE_LEN      (CODE_LEN),
    .CODE          (CODE),
    .TIMEOUT       (TIMEOUT),
    .OPEN_CYCLES   (OPEN_CYCLES),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .sysclk   (sysclk),
    .reset_n  (reset_n),
    .X0_deb   (X0_deb),
    .X1_deb   (X1_deb),
    .unlock   (unlock),
    .error    (error),
    .busy     (busy),
    .bit_count(bit_count)
  );

  initial forever #5 sysclk = ~sysclk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int     kind;
    longint start;
    longint len;
  } ev_t;

  ev_t    exp_q[$];
  bit     model_bits[$];
  longint last_key = 0;
  longint free_at  = 0;
  int     fails    = 0;

  // Rising edge n happens at time 10n+5; at a falling edge this gives the edge just taken.
  function automatic longint last_edge();
    return (longint'($time) - 5) / 10;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_event(input int kind, input longint start, input longint len);
    ev_t ev;
    ev.kind  = kind;
    ev.start = start;
    ev.len   = len;
    exp_q.push_back(ev);
  endfunction

  function automatic void model_fail(input longint e);
    push_event(EV_ERROR, e, 1);
    model_bits.delete();
    free_at = e + 2;
`ifdef LOCKOUT_EN
    fails++;
    if (fails == 3) begin
      free_at = e + 2 + LOCKOUT_CYCLES;
      fails   = 0;
    end
`endif
  endfunction

  // Reference behaviour for rising edge e given the keys presented to it.
  function automatic void model_edge(input longint e, input bit valid, input bit b);
    int val;
    if (valid && e >= free_at) begin
      model_bits.push_back(b);
      last_key = e;
      if (model_bits.size() == CODE_LEN) begin
        val = 0;
        foreach (model_bits[i]) val = val * 2 + int'(model_bits[i]);
        if (val == int'(CODE)) begin
          push_event(EV_UNLOCK, e, OPEN_CYCLES);
          free_at = e + 1 + OPEN_CYCLES;
          fails   = 0;
          model_bits.delete();
        end else begin
          model_fail(e);
        end
      end
    end else if (model_bits.size() > 0 && e - last_key >= TIMEOUT) begin
      model_fail(e);
    end
  endfunction

  task automatic step(input logic x0, input logic x1);
    longint e;
    @(negedge sysclk);
    X0_deb = x0;
    X1_deb = x1;
    e = last_edge() + 1;
    model_edge(e, x0 ^ x1, x1);
    @(posedge sysclk);
    #1;
    X0_deb = 1'b0;
    X1_deb = 1'b0;
    check("bit_count", bit_count, model_bits.size());
    check("busy", busy, (model_bits.size() > 0) || (e + 1 < free_at));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic key(input bit b);
    step(!b, b);
  endtask

  // Enters code[n-1] first down to code[0], with 'gap' cycles between successive keys.
  task automatic keys(input logic [3:0] code, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      key(code[i]);
      if (i > 0 && gap > 1) idle(gap - 1);
    end
  endtask

  task automatic apply_reset(input int hold);
    @(posedge sysclk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_unlock", unlock, 0);
    check("rst_error", error, 0);
    check("rst_busy", busy, 0);
    check("rst_bit_count", bit_count, 0);
    exp_q.delete();
    model_bits.delete();
    free_at = 0;
    fails   = 0;
    repeat (hold) @(posedge sysclk);
    #2;
    reset_n = 1'b1;
  endtask

  task automatic score(input int kind, input longint start, input longint len);
    ev_t ex;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event: kind %0d start %0d len %0d, none expected", kind, start, len);
    end else begin
      ex = exp_q.pop_front();
      check("event_kind", kind, ex.kind);
      check("event_start", start, ex.start);
      check("event_len", len, ex.len);
    end
  endtask

  initial begin : monitor
    logic   u_prev;
    logic   e_prev;
    longint u_start;
    longint e_start;
    longint n;
    u_prev  = 1'b0;
    e_prev  = 1'b0;
    u_start = 0;
    e_start = 0;
    forever begin
      @(negedge sysclk);
      if (!reset_n) begin
        u_prev = 1'b0;
        e_prev = 1'b0;
      end else begin
        n = last_edge();
        if (unlock && !u_prev) u_start = n;
        if (!unlock && u_prev) score(EV_UNLOCK, u_start, n - u_start);
        if (error && !e_prev) e_start = n;
        if (!error && e_prev) score(EV_ERROR, e_start, n - e_start);
        u_prev = unlock;
        e_prev = error;
      end
    end
  end

  initial begin : driver
    #12;
    check("init_unlock", unlock, 0);
    check("init_error", error, 0);
    check("init_busy", busy, 0);
    check("init_bit_count", bit_count, 0);
    @(posedge sysclk);
    #2;
    reset_n = 1'b1;

    // Correct code accepted from the first edge after reset release.
    keys(CODE, 4, 10);
    check("unlock_latency", unlock, 1);
    idle(OPEN_CYCLES + 5);
    check("open_done_busy", busy, 0);

    // Wrong code: one-cycle error, no unlock.
    keys(4'b1001, 4, 10);
    check("error_latency", error, 1);
    check("error_no_unlock", unlock, 0);
    idle(1);
    check("error_one_cycle", error, 0);
    idle(5);

    // Partial entry then silence: error exactly TIMEOUT cycles after the last key.
    keys(4'b0010, 2, 10);
    idle(TIMEOUT - 1);
    check("timeout_not_early", error, 0);
    step(1'b0, 1'b0);
    check("timeout_error", error, 1);
    idle(5);
    keys(CODE, 4, 3);
    idle(OPEN_CYCLES + 5);

    // A key arriving exactly TIMEOUT cycles after the previous one is still accepted.
    key(1'b1);
    idle(TIMEOUT - 1);
    key(1'b0);
    check("gap_at_limit", bit_count, 2);
    keys(4'b0011, 2, 4);
    idle(OPEN_CYCLES + 5);

    // Both keys together mid-entry change nothing.
    key(1'b1);
    key(1'b0);
    step(1'b1, 1'b1);
    check("both_keys_ignored", bit_count, 2);
    key(1'b1);
    key(1'b1);
    check("both_keys_unlock", unlock, 1);
    idle(10);
    keys(4'b1001, 4, 2);
    idle(OPEN_CYCLES);

    // Asynchronous reset in the middle of OPEN.
    keys(CODE, 4, 2);
    idle(20);
    apply_reset(3);
    check("post_reset_busy", busy, 0);
    keys(CODE, 4, 2);
    idle(OPEN_CYCLES + 5);

    // Reset mid-entry discards the partial code.
    keys(4'b0110, 3, 2);
    apply_reset(2);
    keys(CODE, 4, 4);
    idle(OPEN_CYCLES + 5);

    // Three wrong codes in a row, then the right code straight away and after the window.
    for (int k = 0; k < 3; k++) begin
      keys(4'b0000, 4, 2);
      idle(3);
    end
`ifdef LOCKOUT_EN
    check("lockout_busy", busy, 1);
`endif
    keys(CODE, 4, 5);
    idle(LOCKOUT_CYCLES);
    keys(CODE, 4, 5);
    idle(OPEN_CYCLES + 5);

    // Randomized mix of right, wrong, abandoned and ambiguous entries.
    repeat (40) begin
      case ($urandom_range(0, 3))
        0: keys(CODE, 4, int'($urandom_range(1, 12)));
        1: keys(4'($urandom), 4, int'($urandom_range(1, 12)));
        2: begin
          keys(4'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(1, 12)));
          idle(TIMEOUT - 3 + int'($urandom_range(0, 6)));
        end
        default: begin
          key(1'($urandom));
          step(1'b1, 1'b1);
          keys(4'($urandom), 3, int'($urandom_range(1, 5)));
        end
      endcase
      idle(int'($urandom_range(0, 60)));
    end

    idle(LOCKOUT_CYCLES + OPEN_CYCLES + TIMEOUT + 10);
    check("events_pending", exp_q.size(), 0);
    check("final_unlock", unlock, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
